// File: rtl/system_qsys_gpio_if.sv
// Avalon-MM slave port of the GPIO block: word addressed, zero-latency reads.
interface system_qsys_gpio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/system_qsys_gpio.sv
// Parallel I/O port: output data/direction registers, synchronised inputs,
// per-bit edge capture with maskable level interrupt.
module system_qsys_gpio #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 2,
    parameter int               SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    system_qsys_gpio_if.slave   bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic [WIDTH-1:0]    out_port,
    output logic [WIDTH-1:0]    oe,
    output logic                irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_SET     = 3'd4;
    localparam logic [2:0] ADDR_CLEAR   = 3'd5;

    logic [WIDTH-1:0] r_dataOut;
    logic [WIDTH-1:0] r_direction;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_capture;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    logic             w_write;
    logic [WIDTH-1:0] w_wrData;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_captureClear;
    logic [WIDTH-1:0] w_readValue;
    logic             w_unusedWriteBits;

    assign w_write           = bus.chipselect & ~bus.write_n;
    assign w_wrData          = bus.writedata[WIDTH-1:0];
    assign w_unusedWriteBits = ^bus.writedata;
    assign w_sync            = r_sync[SYNC_STAGES-1];

    // Output data register, including the atomic set/clear aliases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dataOut <= RESET_VALUE;
        end else if (w_write) begin
            case (bus.address)
                ADDR_DATA:  r_dataOut <= w_wrData;
                ADDR_SET:   r_dataOut <= r_dataOut | w_wrData;
                ADDR_CLEAR: r_dataOut <= r_dataOut & ~w_wrData;
                default:    r_dataOut <= r_dataOut;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_direction <= '0;
            r_mask      <= '0;
        end else if (w_write) begin
            if (bus.address == ADDR_DIR) begin
                r_direction <= w_wrData;
            end
            if (bus.address == ADDR_MASK) begin
                r_mask <= w_wrData;
            end
        end
    end

    // Metastability chain followed by a history flop for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
        end
    end

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_edge = w_sync & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge = ~w_sync & r_prev;
        end else begin : g_any
            assign w_edge = w_sync ^ r_prev;
        end
    endgenerate

    assign w_captureClear = (w_write && bus.address == ADDR_CAPTURE) ? w_wrData : '0;

    // A new edge arriving in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_capture <= '0;
        end else begin
            r_capture <= (r_capture & ~w_captureClear) | w_edge;
        end
    end

    always_comb begin
        w_readValue = '0;
        case (bus.address)
            ADDR_DATA:    w_readValue = (r_dataOut & r_direction) | (w_sync & ~r_direction);
            ADDR_DIR:     w_readValue = r_direction;
            ADDR_MASK:    w_readValue = r_mask;
            ADDR_CAPTURE: w_readValue = r_capture;
            default:      w_readValue = '0;
        endcase
    end

    assign bus.readdata = 32'(w_readValue);
    assign out_port     = r_dataOut;
    assign oe           = r_direction;
    assign irq          = |(r_capture & r_mask);

endmodule

// File: tb/tb_system_qsys_gpio.sv
// Directed scoreboard bench: instance A (rising edge, 2 sync stages, reset 0x5A)
// and instance B (any edge, 3 sync stages) share clock and reset.
module tb_system_qsys_gpio;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] inPortA, outPortA, oeA;
    logic [7:0] inPortB, outPortB, oeB;
    logic       irqA, irqB;

    expect_t scoreboard[$];
    int      compareCount = 0;
    int      failCount    = 0;

    system_qsys_gpio_if busA ();
    system_qsys_gpio_if busB ();

    system_qsys_gpio #(
        .WIDTH(8), .RESET_VALUE(8'h5A), .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) u_dutA (
        .clk(clk), .reset_n(reset_n), .bus(busA.slave),
        .in_port(inPortA), .out_port(outPortA), .oe(oeA), .irq(irqA)
    );

    system_qsys_gpio #(
        .WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(2), .SYNC_STAGES(3)
    ) u_dutB (
        .clk(clk), .reset_n(reset_n), .bus(busB.slave),
        .in_port(inPortB), .out_port(outPortB), .oe(oeB), .irq(irqB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic pushExpect(input string tag, input logic [31:0] value);
        expect_t e;
        e.tag   = tag;
        e.value = value;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        expect_t e;
        compareCount++;
        assert (scoreboard.size() > 0) else begin
            failCount++;
            $error("[TB] FAIL scoreboard: observed 0x%0h expected <empty queue>", observed);
            return;
        end
        e = scoreboard.pop_front();
        assert (observed === e.value) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", e.tag, observed, e.value);
        end
    endtask

    // Bus write: driven at a falling edge, lands on the next rising edge.
    task automatic applyStimulus(input int sel, input logic [2:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            busA.address = addr; busA.writedata = data; busA.chipselect = 1'b1; busA.write_n = 1'b0;
        end else begin
            busB.address = addr; busB.writedata = data; busB.chipselect = 1'b1; busB.write_n = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        busA.chipselect = 1'b0; busA.write_n = 1'b1;
        busB.chipselect = 1'b0; busB.write_n = 1'b1;
    endtask

    task automatic checkRead(input int sel, input logic [2:0] addr, input string tag,
                             input logic [31:0] expected);
        logic [31:0] data;
        pushExpect(tag, expected);
        if (sel == 0) begin
            busA.address = addr; busA.chipselect = 1'b1; busA.write_n = 1'b1;
            #1 data = busA.readdata;
            busA.chipselect = 1'b0;
        end else begin
            busB.address = addr; busB.chipselect = 1'b1; busB.write_n = 1'b1;
            #1 data = busB.readdata;
            busB.chipselect = 1'b0;
        end
        checkOutput(data);
    endtask

    task automatic checkPin(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        pushExpect(tag, expected);
        checkOutput(observed);
    endtask

    initial begin
        reset_n = 1'b0;
        inPortA = 8'h00;
        inPortB = 8'h00;
        busA.address = 3'd0; busA.chipselect = 1'b0; busA.write_n = 1'b1; busA.writedata = '0;
        busB.address = 3'd0; busB.chipselect = 1'b0; busB.write_n = 1'b1; busB.writedata = '0;
        repeat (2) @(negedge clk);

        checkPin("rstA-out", {24'h0, outPortA}, 32'h5A);
        checkPin("rstA-oe",  {24'h0, oeA},      32'h00);
        checkPin("rstA-irq", {31'h0, irqA},     32'h0);
        checkPin("rstB-out", {24'h0, outPortB}, 32'h00);
        checkPin("rstB-irq", {31'h0, irqB},     32'h0);
        checkRead(0, 3'd1, "rstA-dir", 32'h0);

        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Set/clear aliases on the reset value.
        applyStimulus(0, 3'd4, 32'h01);
        checkPin("setA-out", {24'h0, outPortA}, 32'h5B);
        checkPin("setA-oe",  {24'h0, oeA},      32'h00);
        applyStimulus(0, 3'd5, 32'h10);
        checkPin("clrA-out", {24'h0, outPortA}, 32'h4B);
        checkPin("clrA-oe",  {24'h0, oeA},      32'h00);
        checkRead(0, 3'd4, "setA-read", 32'h0);
        checkRead(0, 3'd5, "clrA-read", 32'h0);

        // Mixed direction read-back with upper write bits ignored.
        applyStimulus(0, 3'd1, 32'h0000_00F0);
        applyStimulus(0, 3'd0, 32'hFFFF_FFA5);
        inPortA = 8'h3C;
        repeat (3) @(negedge clk);
        checkRead(0, 3'd0, "mixA-read", 32'h0000_00AC);
        checkPin("mixA-oe",  {24'h0, oeA},      32'hF0);
        checkPin("mixA-out", {24'h0, outPortA}, 32'hA5);
        checkRead(0, 3'd3, "mixA-capture", 32'h3C);
        checkPin("mixA-irq", {31'h0, irqA}, 32'h0);
        checkRead(0, 3'd6, "resvA-read6", 32'h0);
        applyStimulus(0, 3'd7, 32'hFF);
        checkRead(0, 3'd7, "resvA-read7", 32'h0);
        checkRead(0, 3'd0, "resvA-noeffect", 32'h0000_00AC);
        applyStimulus(0, 3'd3, 32'hFF);
        checkRead(0, 3'd3, "capA-cleared", 32'h0);

        // Rising-only mode ignores a falling input.
        inPortA = 8'h38;
        repeat (3) @(negedge clk);
        checkRead(0, 3'd3, "fallA-ignored", 32'h0);
        applyStimulus(0, 3'd2, 32'h01);
        checkRead(0, 3'd2, "maskA-read", 32'h01);

        // Capture latency: two edges for sync, captured on the third.
        inPortA = 8'h39;
        @(negedge clk);
        checkPin("latA-k-irq", {31'h0, irqA}, 32'h0);
        checkRead(0, 3'd3, "latA-k-cap", 32'h0);
        @(negedge clk);
        checkPin("latA-k1-irq", {31'h0, irqA}, 32'h0);
        checkRead(0, 3'd3, "latA-k1-cap", 32'h0);
        @(negedge clk);
        checkPin("latA-k2-irq", {31'h0, irqA}, 32'h1);
        checkRead(0, 3'd3, "latA-k2-cap", 32'h01);

        // Clear colliding with a new edge on the same bit.
        inPortA = 8'h3B;
        repeat (3) @(negedge clk);
        checkRead(0, 3'd3, "collA-pre", 32'h03);
        inPortA = 8'h3A;
        repeat (3) @(negedge clk);
        inPortA = 8'h3B;
        repeat (2) @(negedge clk);
        applyStimulus(0, 3'd3, 32'h01);
        checkRead(0, 3'd3, "collA-setwins", 32'h03);
        checkPin("collA-irq", {31'h0, irqA}, 32'h1);
        applyStimulus(0, 3'd3, 32'h03);
        checkRead(0, 3'd3, "collA-cleared", 32'h0);
        checkPin("collA-irq0", {31'h0, irqA}, 32'h0);

        // Any-edge instance with three sync stages.
        inPortB = 8'h81;
        repeat (3) @(negedge clk);
        checkRead(1, 3'd3, "latB-early", 32'h0);
        @(negedge clk);
        checkRead(1, 3'd3, "latB-cap", 32'h81);
        checkPin("latB-irq-masked", {31'h0, irqB}, 32'h0);
        applyStimulus(1, 3'd3, 32'hFF);
        checkRead(1, 3'd3, "capB-cleared", 32'h0);
        inPortB = 8'h01;
        repeat (4) @(negedge clk);
        checkRead(1, 3'd3, "fallB-cap", 32'h80);
        checkPin("fallB-irq-masked", {31'h0, irqB}, 32'h0);
        applyStimulus(1, 3'd2, 32'hFF);
        checkPin("maskB-irq", {31'h0, irqB}, 32'h1);
        checkRead(1, 3'd2, "maskB-read", 32'hFF);
        applyStimulus(1, 3'd1, 32'h0F);
        applyStimulus(1, 3'd0, 32'h33);
        checkPin("dataB-out", {24'h0, outPortB}, 32'h33);
        checkPin("dataB-oe",  {24'h0, oeB},      32'h0F);

        // Reset pulse in the middle of a write.
        @(negedge clk);
        busB.address = 3'd0; busB.writedata = 32'hCC; busB.chipselect = 1'b1; busB.write_n = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checkPin("midrstB-irq", {31'h0, irqB},     32'h0);
        checkPin("midrstB-out", {24'h0, outPortB}, 32'h00);
        checkPin("midrstB-oe",  {24'h0, oeB},      32'h00);
        checkPin("midrstA-out", {24'h0, outPortA}, 32'h5A);
        @(negedge clk);
        busB.chipselect = 1'b0; busB.write_n = 1'b1;
        reset_n = 1'b1;
        checkRead(1, 3'd2, "postrstB-mask", 32'h0);
        checkRead(1, 3'd3, "postrstB-cap", 32'h0);
        checkPin("postrstB-out", {24'h0, outPortB}, 32'h00);

        // Inputs held high across reset release produce one capture.
        repeat (2) @(negedge clk);
        checkRead(0, 3'd3, "relA-early", 32'h0);
        @(negedge clk);
        checkRead(0, 3'd3, "relA-cap", 32'h3B);
        checkRead(0, 3'd0, "relA-data", 32'h3B);
        checkPin("relA-irq", {31'h0, irqA}, 32'h0);
        repeat (4) @(negedge clk);
        checkRead(1, 3'd3, "relB-cap", 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
